// File: rtl/node_pkg.sv
// Shared types and constants for the mesh router node: FSM state encoding and
// input-link numbering.
package node_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2
    } node_state_e;

    localparam int NUM_PORTS_DEF = 4;
    localparam int PORT_N        = 0;
    localparam int PORT_E        = 1;
    localparam int PORT_S        = 2;
    localparam int PORT_W        = 3;
    localparam int PORT_IDX_W    = $clog2(NUM_PORTS_DEF);

endpackage

// File: rtl/node_port_arbiter_if.sv
// Handshake and status bundle between the input arbiter (master) and the
// upstream links, downstream ack and the debug observers (slave).
interface node_port_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int CNT_W     = 8
);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0] in_valid;
    logic [NUM_PORTS-1:0] to_in_ack;
    logic                 load_en;
    logic [IDX_W-1:0]     load_sel;
    logic                 buf_valid;
    logic                 from_out_ack;
    logic                 timeout_err;
    logic [CNT_W-1:0]     drop_count;
    logic [IDX_W-1:0]     rr_ptr;

    modport master (
        input  in_valid, from_out_ack,
        output to_in_ack, load_en, load_sel, buf_valid, timeout_err, drop_count, rr_ptr
    );

    modport slave (
        output in_valid, from_out_ack,
        input  to_in_ack, load_en, load_sel, buf_valid, timeout_err, drop_count, rr_ptr
    );
endinterface

// File: rtl/node_rr_picker.sv
// Combinational round-robin picker: first set request bit scanning circularly
// upward from the priority pointer. Shared with the output-side arbiter.
module node_rr_picker #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic                 found,
    output logic [IDX_W-1:0]     idx
);

    // Circular priority scan starting at ptr
    always_comb begin
        found = 1'b0;
        idx   = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            int j;
            j = (int'(ptr) + i) % NUM_PORTS;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/node_port_arbiter.sv
// Round-robin input arbiter and buffer sequencer for one mesh router node:
// grants one link, strobes the buffer load, holds it until downstream ack or timeout.
module node_port_arbiter
    import node_pkg::*;
#(
    parameter int NUM_PORTS      = NUM_PORTS_DEF,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic               clk,
    input  logic               rst,
    node_port_arbiter_if.master bus
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    generate
        if (longint'(TIMEOUT_CYCLES) >= (longint'(1) << CNT_W)) begin : g_cnt_too_narrow
            $error("TIMEOUT_CYCLES does not fit in CNT_W bits");
        end
    endgenerate

    node_state_e          state_r, next_state_s;
    logic [IDX_W-1:0]     load_sel_r, rr_ptr_r;
    logic [CNT_W-1:0]     busy_cnt_r, drop_cnt_r;
    logic [NUM_PORTS-1:0] ack_r, ack_s;
    logic                 load_en_r, load_en_s;
    logic                 buf_valid_r, buf_valid_s;
    logic                 timeout_err_r, drop_s;
    logic                 timeout_hit_s;
    logic                 pick_found_s;
    logic [IDX_W-1:0]     pick_idx_s;

    node_rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req   (bus.in_valid),
        .ptr   (rr_ptr_r),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Watchdog threshold detect; a zero threshold disables it
    always_comb begin
        if (TIMEOUT_CYCLES != 0) begin
            timeout_hit_s = (busy_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; downstream ack takes precedence over the watchdog
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_found_s) next_state_s = LOAD;
                else              next_state_s = IDLE;
            end
            LOAD: next_state_s = BUSY;
            BUSY: begin
                if (bus.from_out_ack)   next_state_s = IDLE;
                else if (timeout_hit_s) next_state_s = IDLE;
                else                    next_state_s = BUSY;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode from the next state so the Moore outputs can be registered
    always_comb begin
        ack_s       = {NUM_PORTS{1'b0}};
        load_en_s   = (next_state_s == LOAD);
        buf_valid_s = (next_state_s == BUSY);
        drop_s      = (state_r == BUSY) && !bus.from_out_ack && timeout_hit_s;
        if (next_state_s == LOAD) begin
            ack_s[pick_idx_s] = 1'b1;
        end else begin
            ack_s = {NUM_PORTS{1'b0}};
        end
    end

    // Output registers, grant bookkeeping and counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            ack_r         <= {NUM_PORTS{1'b0}};
            load_en_r     <= 1'b0;
            buf_valid_r   <= 1'b0;
            timeout_err_r <= 1'b0;
            load_sel_r    <= {IDX_W{1'b0}};
            rr_ptr_r      <= {IDX_W{1'b0}};
            busy_cnt_r    <= {CNT_W{1'b0}};
            drop_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            ack_r         <= ack_s;
            load_en_r     <= load_en_s;
            buf_valid_r   <= buf_valid_s;
            timeout_err_r <= drop_s;
            if (state_r == IDLE && pick_found_s) begin
                load_sel_r <= pick_idx_s;
                rr_ptr_r   <= (pick_idx_s == IDX_W'(NUM_PORTS - 1)) ? {IDX_W{1'b0}}
                                                                     : pick_idx_s + IDX_W'(1);
            end else begin
                load_sel_r <= load_sel_r;
                rr_ptr_r   <= rr_ptr_r;
            end
            if (state_r == LOAD) begin
                busy_cnt_r <= {CNT_W{1'b0}};
            end else if (state_r == BUSY && busy_cnt_r != {CNT_W{1'b1}}) begin
                busy_cnt_r <= busy_cnt_r + CNT_W'(1);
            end else begin
                busy_cnt_r <= busy_cnt_r;
            end
            if (drop_s && drop_cnt_r != {CNT_W{1'b1}}) begin
                drop_cnt_r <= drop_cnt_r + CNT_W'(1);
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    assign bus.to_in_ack   = ack_r;
    assign bus.load_en     = load_en_r;
    assign bus.load_sel    = load_sel_r;
    assign bus.buf_valid   = buf_valid_r;
    assign bus.timeout_err = timeout_err_r;
    assign bus.drop_count  = drop_cnt_r;
    assign bus.rr_ptr      = rr_ptr_r;

endmodule

// File: tb/tb_node_port_arbiter.sv
// Directed self-checking bench for node_port_arbiter with a 4-cycle watchdog.
module tb_node_port_arbiter;

    localparam int NP = 4;
    localparam int CW = 8;
    localparam int TO = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    node_port_arbiter_if #(.NUM_PORTS(NP), .CNT_W(CW)) bus ();

    node_port_arbiter #(
        .NUM_PORTS      (NP),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".ack"},   32'(bus.to_in_ack),   32'h0);
        check({tag, ".load"},  32'(bus.load_en),     32'h0);
        check({tag, ".bv"},    32'(bus.buf_valid),   32'h0);
        check({tag, ".terr"},  32'(bus.timeout_err), 32'h0);
        check({tag, ".sel"},   32'(bus.load_sel),    32'h0);
        check({tag, ".ptr"},   32'(bus.rr_ptr),      32'h0);
    endtask

    initial begin
        int bv_cnt;
        int terr_cnt;
        logic [NP-1:0] ack_or;
        logic [31:0]   exp_ack;

        checks           = 0;
        errors           = 0;
        rst              = 1'b0;
        bus.in_valid     = 4'b0000;
        bus.from_out_ack = 1'b0;
        step();
        step();
        check_idle_outputs("reset");
        check("reset.drop", 32'(bus.drop_count), 32'h0);
        rst = 1'b1;
        step();

        // Single request on link 3
        bus.in_valid = 4'b1000;
        step();
        check("single.ack",  32'(bus.to_in_ack), 32'h8);
        check("single.load", 32'(bus.load_en),   32'h1);
        check("single.sel",  32'(bus.load_sel),  32'h3);
        check("single.ptr",  32'(bus.rr_ptr),    32'h0);
        check("single.bv0",  32'(bus.buf_valid), 32'h0);
        bus.in_valid = 4'b0000;
        step();
        check("single.bv1",   32'(bus.buf_valid), 32'h1);
        check("single.ack1",  32'(bus.to_in_ack), 32'h0);
        check("single.load1", 32'(bus.load_en),   32'h0);
        step();
        check("single.bv2", 32'(bus.buf_valid), 32'h1);
        bus.from_out_ack = 1'b1;
        step();
        bus.from_out_ack = 1'b0;
        check("single.bv_off", 32'(bus.buf_valid),   32'h0);
        check("single.terr",   32'(bus.timeout_err), 32'h0);

        // Fairness: all links requesting, downstream acks every BUSY cycle
        bus.in_valid     = 4'b1111;
        bus.from_out_ack = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            exp_ack = (k % 3 == 1) ? (32'h1 << (((k - 1) / 3) % 4)) : 32'h0;
            check($sformatf("fair.ack%0d", k), 32'(bus.to_in_ack), exp_ack);
        end
        bus.in_valid     = 4'b0000;
        bus.from_out_ack = 1'b0;
        check("fair.ptr", 32'(bus.rr_ptr), 32'h1);
        step();

        // Watchdog drop: rr_ptr=1, link 2 requests, no downstream ack
        bus.in_valid = 4'b0100;
        step();
        check("to.ack", 32'(bus.to_in_ack), 32'h4);
        check("to.sel", 32'(bus.load_sel),  32'h2);
        check("to.ptr", 32'(bus.rr_ptr),    32'h3);
        bus.in_valid = 4'b0000;
        bv_cnt   = 0;
        terr_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (bus.buf_valid)   bv_cnt++;
            if (bus.timeout_err) terr_cnt++;
        end
        check("to.bv_cycles", 32'(bv_cnt),         32'd4);
        check("to.terr_cnt",  32'(terr_cnt),       32'd1);
        check("to.drop",      32'(bus.drop_count), 32'd1);

        // Ack coincident with the timeout cycle: ack wins
        bus.in_valid = 4'b0010;
        step();
        check("co.ack", 32'(bus.to_in_ack), 32'h2);
        bus.in_valid = 4'b0000;
        step();
        step();
        step();
        step();
        check("co.bv4", 32'(bus.buf_valid), 32'h1);
        bus.from_out_ack = 1'b1;
        step();
        bus.from_out_ack = 1'b0;
        check("co.terr", 32'(bus.timeout_err), 32'h0);
        check("co.bv",   32'(bus.buf_valid),   32'h0);
        check("co.drop", 32'(bus.drop_count),  32'd1);
        step();
        check("co.terr_late", 32'(bus.timeout_err), 32'h0);

        // Saturation: 299 more drops on top of the first one
        bus.in_valid = 4'b0001;
        repeat (299 * 6) step();
        bus.in_valid = 4'b0000;
        repeat (8) step();
        check("sat.drop", 32'(bus.drop_count), 32'd255);

        // Reset during LOAD
        bus.in_valid = 4'b1000;
        step();
        check("rl.ack", 32'(bus.to_in_ack), 32'h8);
        rst          = 1'b0;
        bus.in_valid = 4'b0000;
        step();
        check_idle_outputs("rl");
        check("rl.drop", 32'(bus.drop_count), 32'h0);
        rst    = 1'b1;
        ack_or = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            step();
            ack_or = ack_or | bus.to_in_ack;
        end
        check("rl.no_ack", 32'(ack_or), 32'h0);
        check("rl.bv",     32'(bus.buf_valid), 32'h0);

        // Reset during BUSY
        bus.in_valid = 4'b0100;
        step();
        check("rb.ack", 32'(bus.to_in_ack), 32'h4);
        bus.in_valid = 4'b0000;
        step();
        check("rb.bv1", 32'(bus.buf_valid), 32'h1);
        rst = 1'b0;
        step();
        check_idle_outputs("rb");
        rst      = 1'b1;
        ack_or   = 4'b0000;
        terr_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            ack_or = ack_or | bus.to_in_ack;
            if (bus.timeout_err) terr_cnt++;
        end
        check("rb.no_ack",  32'(ack_or),         32'h0);
        check("rb.no_terr", 32'(terr_cnt),       32'd0);
        check("rb.drop",    32'(bus.drop_count), 32'd0);

        // Stale valid held one cycle past its ack
        bus.in_valid = 4'b0001;
        step();
        check("stale.ack", 32'(bus.to_in_ack), 32'h1);
        ack_or = 4'b0000;
        step();
        ack_or = ack_or | bus.to_in_ack;
        bus.in_valid = 4'b0000;
        step();
        ack_or = ack_or | bus.to_in_ack;
        bus.from_out_ack = 1'b1;
        step();
        ack_or = ack_or | bus.to_in_ack;
        bus.from_out_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            ack_or = ack_or | bus.to_in_ack;
        end
        check("stale.no_regrant", 32'(ack_or),        32'h0);
        check("stale.ptr",        32'(bus.rr_ptr),    32'h1);
        check("stale.bv",         32'(bus.buf_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
